// File: rtl/booth_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier:
// the FSM encoding, the signed digit values and the digit-count derivation.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic signed [2:0] DIG_Z  = 3'sd0;
  localparam logic signed [2:0] DIG_P1 = 3'sd1;
  localparam logic signed [2:0] DIG_P2 = 3'sd2;
  localparam logic signed [2:0] DIG_M1 = -3'sd1;
  localparam logic signed [2:0] DIG_M2 = -3'sd2;

  function automatic int ndig(input int length);
    return length / 2;
  endfunction

  // Radix-4 recoding of the overlapping triplet {b[2i+1], b[2i], b[2i-1]}.
  function automatic logic signed [2:0] booth_digit(input logic [2:0] trip);
    logic signed [2:0] d;
    case (trip)
      3'b001, 3'b010: d = DIG_P1;
      3'b011:         d = DIG_P2;
      3'b100:         d = DIG_M2;
      3'b101, 3'b110: d = DIG_M1;
      default:        d = DIG_Z;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Combinational radix-4 Booth digit encoder: pp = digit(triplet) * a, signed,
// two bits wider than a so that -2 * (most negative a) still fits.
module booth_r4_enc
  import booth_pkg::*;
#(
  parameter int LENGTH = 8
) (
  input  logic [LENGTH-1:0] a_i,
  input  logic [2:0]        trip_i,
  output logic [LENGTH+1:0] pp_o
);

  logic signed [LENGTH+1:0] a_ext;
  logic signed [LENGTH+1:0] a_dbl;

  assign a_ext = {{2{a_i[LENGTH-1]}}, a_i};
  assign a_dbl = {a_i[LENGTH-1], a_i, 1'b0};

  always_comb begin
    pp_o = '0;
    case (booth_digit(trip_i))
      DIG_P1:  pp_o = a_ext;
      DIG_P2:  pp_o = a_dbl;
      DIG_M1:  pp_o = -a_ext;
      DIG_M2:  pp_o = -a_dbl;
      default: pp_o = '0;
    endcase
  end

endmodule

// File: rtl/booth_iter_seq.sv
// Iterative radix-4 Booth multiplier: one shared digit encoder walks the
// multiplier two bits per cycle, accumulating shifted partial products.
module booth_iter_seq
  import booth_pkg::*;
#(
  parameter int LENGTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [LENGTH-1:0]   a_i,
  input  logic [LENGTH-1:0]   b_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [2*LENGTH-1:0] p_o,
  output logic                busy_o
);

  localparam int NDIG = ndig(LENGTH);
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PW   = 2 * LENGTH;
  localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [LENGTH-1:0] a_q, a_d;
  logic [LENGTH:0] m_q, m_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   p_q, p_d;

  logic [LENGTH+1:0] pp;
  logic [PW-1:0]     pp_ext;
  logic [PW-1:0]     pp_sh;
  logic [PW-1:0]     acc_sum;

  booth_r4_enc #(.LENGTH(LENGTH)) u_enc (
    .a_i    (a_q),
    .trip_i (m_q[2:0]),
    .pp_o   (pp)
  );

  // Digit i carries weight 4^i; the sum wraps modulo 2^PW, which is exact
  // because the true product always fits in PW signed bits.
  assign pp_ext  = {{(PW-LENGTH-2){pp[LENGTH+1]}}, pp};
  assign pp_sh   = pp_ext << {cnt_q, 1'b0};
  assign acc_sum = acc_q + pp_sh;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    m_d     = m_q;
    acc_d   = acc_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d     = a_i;
          m_d     = {b_i, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_sum;
        m_d   = {{2{m_q[LENGTH]}}, m_q[LENGTH:2]};
        if (cnt_q == CNT_LAST) begin
          p_d     = acc_sum;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q == CALC);
  assign out_valid_o = (state_q == DONE);
  assign p_o         = p_q;

endmodule

// File: doc/booth_iter_seq.md
Name: booth_iter_seq

Overview:
- Iterative radix-4 Booth multiplier sequencer for the Booth_pipeline datapath.
- One radix-4 digit encoder is time-shared across all LENGTH/2 multiplier digits instead of instantiating one encoder per digit.
- Accepts a signed operand pair over a valid/ready handshake, walks the multiplier two bits per cycle, and accumulates shifted partial products.
- Returns a signed 2*LENGTH-bit product over a second valid/ready handshake. Area-reduced alternative to the fully pipelined multiplier.

Parameters:
- LENGTH, 8, operand width in bits; must be even and >= 4.
- NDIG, LENGTH/2, number of radix-4 digits (localparam, derived; not overridable).

Ports:
- clk_i  in  1  single clock; all state changes on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  block can accept operands.
- a_i  in  LENGTH  multiplicand, signed two's complement.
- b_i  in  LENGTH  multiplier, signed two's complement.
- out_valid_o  out  1  product valid.
- out_ready_i  in  1  consumer accepts product.
- p_o  out  2*LENGTH  signed product a_i*b_i.
- busy_o  out  1  high while in CALC.

Behaviour:
- Reset (rst_i=1 at an edge): state=IDLE, cnt=0, accumulator=0, p_o=0, out_valid_o=0, busy_o=0. in_ready_o=1 combinationally from IDLE.
- Reset mid-operation aborts immediately. Any in-flight operation is discarded and no out_valid_o pulse follows.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i&in_ready_o: latch A=a_i, load multiplier shift reg M={b_i,1'b0} (LENGTH+1 bits), clear accumulator, cnt=0, go to CALC.
- CALC:
  - in_ready_o=0, busy_o=1.
  - Each cycle, triplet t=M[2:0] is encoded to digit d: 000/111->0, 001/010->+1, 011->+2, 100->-2, 101/110->-1.
  - Partial product pp = d*A, signed, LENGTH+2 bits.
  - acc <= acc + (sext(pp) << 2*cnt), computed modulo 2^(2*LENGTH).
  - M <= M >>> 2 (arithmetic shift); cnt <= cnt+1.
  - When cnt==NDIG-1 the final accumulation lands, p_o <= final acc, state goes to DONE.
- DONE:
  - out_valid_o=1. p_o is held stable until out_valid_o&out_ready_i, then go to IDLE with out_valid_o=0.
  - No same-cycle re-accept: in_ready_o stays 0 in DONE.
- Latency: product is valid exactly NDIG cycles after the acceptance edge (4 cycles for LENGTH=8). Throughput is one operation per NDIG+2 cycles with out_ready_i held high.
- in_valid_i outside IDLE is ignored; the upstream must hold operands until in_ready_o is seen.
- a_i/b_i changing after acceptance has no effect.
- Width rules:
  - -2*A needs LENGTH+2 bits; A=-2^(LENGTH-1) gives +2^LENGTH, which fits.
  - Final result is exact for all signed inputs, including (-2^(LENGTH-1))^2 = 2^(2*LENGTH-2).
- cnt width is clog2(NDIG), min 1. cnt never wraps past NDIG-1 in CALC.
- out_ready_i held high in IDLE/CALC has no effect.

Decomposition:
- Shared package booth_pkg:
  - FSM state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2).
  - Digit encoding constants.
  - NDIG derivation function.
- One sub-module, booth_r4_enc (combinational): inputs A (LENGTH), triplet (3); output pp (LENGTH+2), where pp = digit*A as signed.
- The sequencer owns the FSM, counter, shift register and accumulator.

Test Plan:
- a=3, b=5, out_ready_i=1 -> out_valid_o rises 4 cycles after the accept edge, p_o=16'h000F, in_ready_o=0 during CALC/DONE.
- a=-128 (8'h80), b=-128 -> p_o=16'h4000; a=-128, b=127 -> p_o=16'hC080 (-16256); a=0, b=8'h5A -> p_o=0.
- Back-pressure: a=-7, b=9 with out_ready_i=0 for 5 cycles after out_valid_o -> p_o=16'hFFC1 held stable, no new accept while in_valid_i=1 and a_i/b_i change; release -> one handshake, then IDLE.
- Reset mid-CALC: assert rst_i on the 2nd CALC cycle -> next cycle IDLE, out_valid_o=0, p_o=0, no product pulse; a following op 12*-11 yields 16'hFF7C.
- Back-to-back random: 200 random signed pairs with random in_valid_i/out_ready_i gaps -> every p_o equals the scoreboard a*b, product order matches accept order, no drops or duplicates.
